// File: rtl/pll_reset_sequencer_if.sv
// Connection bundle between the PLL reset sequencer and its surroundings.
//
// Signals:
//   locked          - PLL LOCKED pin, asynchronous to the sequencer clock
//   relock_req      - single-cycle request to restart the PLL reset sequence
//   pll_rst         - drives the PLL RST pin, active high
//   sys_rst         - synchronous reset for downstream logic, active high
//   ready           - high only while the PLL is locked and stable (RUN)
//   lock_loss_count - saturating count of lock losses seen while running
//   timeout_count   - saturating count of lock-wait timeouts
//
// master: the sequencer side. slave: the PLL / test-top side.
interface pll_reset_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             locked;
    logic             relock_req;
    logic             pll_rst;
    logic             sys_rst;
    logic             ready;
    logic [CNT_W-1:0] lock_loss_count;
    logic [CNT_W-1:0] timeout_count;

    modport master (
        input  locked,
        input  relock_req,
        output pll_rst,
        output sys_rst,
        output ready,
        output lock_loss_count,
        output timeout_count
    );

    modport slave (
        output locked,
        output relock_req,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  lock_loss_count,
        input  timeout_count
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL RST pin, waits for LOCKED, requires a
// run of consecutive locked cycles, then releases a synchronous system reset.
// Any lock loss in RUN or an explicit relock request starts a new attempt.
// Lock losses and lock-wait timeouts are counted in saturating counters.
//
// Ports:
//   clk       - PLL reference clock, the only clock
//   cpu_reset - synchronous active-high reset
//   bus       - master modport of pll_reset_sequencer_if (locked, relock_req
//               in; pll_rst, sys_rst, ready, lock_loss_count, timeout_count out)
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 64,
    parameter int CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    cpu_reset,
    pll_reset_sequencer_if.master   bus
);
    localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_C  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CYC_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CYC_W-1:0] RST_LAST    = CYC_W'(RST_CYCLES - 1);
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT - 1);
    localparam logic [CYC_W-1:0] STABLE_LAST = CYC_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {
        RST_HOLD,
        WAIT_LOCK,
        STABLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CYC_W-1:0] cycle_cnt;
    logic             cnt_clear;
    logic             timeout_hit;
    logic             loss_hit;
    logic             locked_p0;
    logic             locked_p1;
    logic             locked_s;
    logic             pll_rst_p0;
    logic             sys_rst_p0;
    logic             ready_p0;
    logic [CNT_W-1:0] loss_cnt;
    logic [CNT_W-1:0] timeout_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign locked_s = locked_p1;

    // Next-state decode; relock_req overrides every other transition.
    always_comb begin
        state_next  = state;
        cnt_clear   = 1'b0;
        timeout_hit = 1'b0;
        loss_hit    = 1'b0;
        if (bus.relock_req) begin
            state_next = RST_HOLD;
            cnt_clear  = 1'b1;
        end else begin
            case (state)
                RST_HOLD: begin
                    if (cycle_cnt == RST_LAST) state_next = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_next = STABLE;
                    end else if (cycle_cnt == TIMEOUT_LAST) begin
                        state_next  = RST_HOLD;
                        timeout_hit = 1'b1;
                    end
                end
                STABLE: begin
                    if (!locked_s) state_next = WAIT_LOCK;
                    else if (cycle_cnt == STABLE_LAST) state_next = RUN;
                end
                RUN: begin
                    if (!locked_s) begin
                        state_next = RST_HOLD;
                        loss_hit   = 1'b1;
                    end
                end
                default: state_next = RST_HOLD;
            endcase
        end
        if (state_next != state) cnt_clear = 1'b1;
    end

    // Register stage: synchronizer, state, cycle counter, event counters and
    // outputs decoded from state_next so they switch on the same edge as state.
    always_ff @(posedge clk) begin
        if (cpu_reset) begin
            state       <= RST_HOLD;
            cycle_cnt   <= '0;
            locked_p0   <= 1'b0;
            locked_p1   <= 1'b0;
            loss_cnt    <= '0;
            timeout_cnt <= '0;
            pll_rst_p0  <= 1'b1;
            sys_rst_p0  <= 1'b1;
            ready_p0    <= 1'b0;
        end else begin
            state     <= state_next;
            locked_p0 <= bus.locked;
            locked_p1 <= locked_p0;
            // RUN has no timed exit, so the counter is parked there.
            if (cnt_clear) cycle_cnt <= '0;
            else if (state != RUN) cycle_cnt <= cycle_cnt + CYC_W'(1);
            if (timeout_hit) timeout_cnt <= sat_inc(timeout_cnt);
            if (loss_hit) loss_cnt <= sat_inc(loss_cnt);
            pll_rst_p0 <= (state_next == RST_HOLD);
            sys_rst_p0 <= (state_next != RUN);
            ready_p0   <= (state_next == RUN);
        end
    end

    assign bus.pll_rst         = pll_rst_p0;
    assign bus.sys_rst         = sys_rst_p0;
    assign bus.ready           = ready_p0;
    assign bus.lock_loss_count = loss_cnt;
    assign bus.timeout_count   = timeout_cnt;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer (RST_CYCLES=4, LOCK_TIMEOUT=32,
// STABLE_CYCLES=8, CNT_W=4): scripted vector table, timeout saturation run,
// and randomized traffic against a countdown-based reference model.
module tb_pll_reset_sequencer;
    localparam int RC   = 4;
    localparam int LT   = 32;
    localparam int SC   = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    localparam int M_HOLD = 0;
    localparam int M_WAIT = 1;
    localparam int M_STAB = 2;
    localparam int M_RUN  = 3;

    logic clk = 1'b0;
    logic cpu_reset;

    pll_reset_sequencer_if #(.CNT_W(CW)) bus();

    pll_reset_sequencer #(
        .RST_CYCLES(RC),
        .LOCK_TIMEOUT(LT),
        .STABLE_CYCLES(SC),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .cpu_reset(cpu_reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase plus cycles remaining in that phase.
    int m_mode = M_HOLD;
    int m_left = RC;
    int m_loss = 0;
    int m_tout = 0;
    bit m_s0   = 1'b0;
    bit m_s1   = 1'b0;

    typedef struct {
        int n;
        int rst;
        int lk;
        int rq;
        int pll;
        int sys;
        int rdy;
        int loss;
        int tout;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit l, input bit q);
        bit ls;
        ls = m_s1;
        if (r) begin
            m_mode = M_HOLD;
            m_left = RC;
            m_loss = 0;
            m_tout = 0;
            m_s0   = 1'b0;
            m_s1   = 1'b0;
        end else begin
            m_s1 = m_s0;
            m_s0 = l;
            if (q) begin
                m_mode = M_HOLD;
                m_left = RC;
            end else begin
                case (m_mode)
                    M_HOLD: if (m_left == 1) begin m_mode = M_WAIT; m_left = LT; end
                            else m_left--;
                    M_WAIT: if (ls) begin m_mode = M_STAB; m_left = SC; end
                            else if (m_left == 1) begin
                                m_mode = M_HOLD; m_left = RC;
                                if (m_tout < CMAX) m_tout++;
                            end else m_left--;
                    M_STAB: if (!ls) begin m_mode = M_WAIT; m_left = LT; end
                            else if (m_left == 1) m_mode = M_RUN;
                            else m_left--;
                    default: if (!ls) begin
                                m_mode = M_HOLD; m_left = RC;
                                if (m_loss < CMAX) m_loss++;
                            end
                endcase
            end
        end
    endtask

    task automatic check_model();
        bit bad;
        check("model_outs", {29'd0, bus.pll_rst, bus.sys_rst, bus.ready},
              {29'd0, m_mode == M_HOLD, m_mode != M_RUN, m_mode == M_RUN});
        check("model_loss", 32'(bus.lock_loss_count), m_loss);
        check("model_tout", 32'(bus.timeout_count), m_tout);
        bad = (bus.pll_rst && !bus.sys_rst) || (bus.ready == bus.sys_rst);
        check("invariant", 32'(bad), 0);
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic step(input bit r, input bit l, input bit q);
        cpu_reset      = r;
        bus.locked     = l;
        bus.relock_req = q;
        @(posedge clk);
        #1;
        model_step(r, l, q);
        check_model();
    endtask

    initial begin
        cpu_reset      = 1'b1;
        bus.locked     = 1'b0;
        bus.relock_req = 1'b0;

        //             n  rst lk rq  pll sys rdy loss tout
        vq.push_back('{2,  1, 0, 0,  1,  1,  0,  0,  0});  // reset state
        vq.push_back('{3,  0, 0, 0,  1,  1,  0,  0,  0});  // first RST pulse
        vq.push_back('{1,  0, 0, 0,  0,  1,  0,  0,  0});  // 4th cycle -> WAIT
        vq.push_back('{31, 0, 0, 0,  0,  1,  0,  0,  0});
        vq.push_back('{1,  0, 0, 0,  1,  1,  0,  0,  1});  // timeout
        vq.push_back('{4,  0, 0, 0,  0,  1,  0,  0,  1});
        vq.push_back('{9,  0, 0, 0,  0,  1,  0,  0,  1});
        vq.push_back('{2,  0, 1, 0,  0,  1,  0,  0,  1});  // lock rises
        vq.push_back('{1,  0, 1, 0,  0,  1,  0,  0,  1});  // -> STABLE
        vq.push_back('{7,  0, 1, 0,  0,  1,  0,  0,  1});
        vq.push_back('{1,  0, 1, 0,  0,  0,  1,  0,  1});  // -> RUN
        vq.push_back('{2,  0, 0, 0,  0,  0,  1,  0,  1});  // loss in sync
        vq.push_back('{1,  0, 0, 0,  1,  1,  0,  1,  1});  // loss acted on
        vq.push_back('{1,  0, 0, 1,  1,  1,  0,  1,  1});  // relock in HOLD
        vq.push_back('{4,  0, 1, 0,  0,  1,  0,  1,  1});
        vq.push_back('{1,  0, 1, 0,  0,  1,  0,  1,  1});
        vq.push_back('{7,  0, 1, 0,  0,  1,  0,  1,  1});
        vq.push_back('{1,  0, 1, 0,  0,  0,  1,  1,  1});  // RUN again
        vq.push_back('{1,  0, 1, 1,  1,  1,  0,  1,  1});  // relock in RUN
        vq.push_back('{3,  0, 1, 0,  1,  1,  0,  1,  1});
        vq.push_back('{1,  0, 1, 0,  0,  1,  0,  1,  1});
        vq.push_back('{1,  0, 1, 0,  0,  1,  0,  1,  1});
        vq.push_back('{7,  0, 1, 0,  0,  1,  0,  1,  1});
        vq.push_back('{1,  0, 1, 0,  0,  0,  1,  1,  1});
        vq.push_back('{2,  0, 0, 0,  0,  0,  1,  1,  1});
        vq.push_back('{1,  0, 0, 1,  1,  1,  0,  1,  1});  // relock + loss: no count
        vq.push_back('{4,  0, 1, 0,  0,  1,  0,  1,  1});
        vq.push_back('{1,  0, 1, 0,  0,  1,  0,  1,  1});
        vq.push_back('{8,  0, 1, 0,  0,  0,  1,  1,  1});
        vq.push_back('{1,  1, 1, 0,  1,  1,  0,  0,  0});  // cpu_reset in RUN
        vq.push_back('{4,  0, 1, 0,  0,  1,  0,  0,  0});
        vq.push_back('{1,  0, 1, 0,  0,  1,  0,  0,  0});  // STABLE
        vq.push_back('{3,  0, 1, 0,  0,  1,  0,  0,  0});
        vq.push_back('{2,  0, 0, 0,  0,  1,  0,  0,  0});  // chatter
        vq.push_back('{1,  0, 1, 0,  0,  1,  0,  0,  0});  // back to WAIT
        vq.push_back('{1,  0, 1, 0,  0,  1,  0,  0,  0});
        vq.push_back('{1,  0, 1, 0,  0,  1,  0,  0,  0});  // STABLE again
        vq.push_back('{7,  0, 1, 0,  0,  1,  0,  0,  0});
        vq.push_back('{1,  0, 1, 0,  0,  0,  1,  0,  0});  // full 8 then RUN

        foreach (vq[i]) begin
            repeat (vq[i].n) step(vq[i].rst[0], vq[i].lk[0], vq[i].rq[0]);
            check($sformatf("vec%0d_outs", i),
                  {29'd0, bus.pll_rst, bus.sys_rst, bus.ready},
                  32'((vq[i].pll << 2) | (vq[i].sys << 1) | vq[i].rdy));
            check($sformatf("vec%0d_loss", i), 32'(bus.lock_loss_count), vq[i].loss);
            check($sformatf("vec%0d_tout", i), 32'(bus.timeout_count), vq[i].tout);
        end

        // Never locking: 36-cycle retry period, timeout count saturating at 15.
        step(1'b1, 1'b0, 1'b0);
        for (int e = 1; e <= 36 * 17; e++) begin
            step(1'b0, 1'b0, 1'b0);
            check("sat_pll", 32'(bus.pll_rst), ((e % 36) < 4) ? 1 : 0);
            check("sat_sys", 32'(bus.sys_rst), 1);
            check("sat_tout", 32'(bus.timeout_count), ((e / 36) > CMAX) ? CMAX : (e / 36));
        end

        // Randomized traffic against the model.
        begin
            bit lk;
            bit l;
            lk = 1'b1;
            step(1'b1, 1'b0, 1'b0);
            for (int c = 0; c < 4000; c++) begin
                if ($urandom_range(39) == 0) lk = !lk;
                l = lk;
                if ($urandom_range(49) == 0) l = !lk;
                step($urandom_range(1499) == 0, l, $urandom_range(299) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
